cursor_overlay_renderer: RTL



---
 rtl/common.sv | 10 +
 rtl/cursor_overlay_renderer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/common.sv
// Shared VGA pipeline colour definitions.
// Colour width and the transparent "no overlay" code.
package common_pkg;
  localparam int COLOR_WIDTH = 3;
  localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = 3'd0;
  localparam logic [COLOR_WIDTH-1:0] COLOR_BLUE  = 3'd1;
  localparam logic [COLOR_WIDTH-1:0] COLOR_GREEN = 3'd2;
  localparam logic [COLOR_WIDTH-1:0] COLOR_RED   = 3'd4;
  localparam logic [COLOR_WIDTH-1:0] COLOR_WHITE = 3'd7;
endpackage

// File: rtl/cursor_overlay_renderer.sv
// Multi-cursor overlay frame buffer: clears, then erases/redraws square
// cursors one pixel per clock, round-robin over cursors.
// Ports: clk, reset (sync, active-high); cursor_en/x/y/color/size packed
// per cursor; request_x/y read address; render_color registered pixel
// (1-cycle latency); busy high whenever the engine is not scanning.
module cursor_overlay_renderer
  import common_pkg::*;
#(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int NUM_CURSORS = 2,
  parameter int MAX_SIZE    = 4,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int IW = (NUM_CURSORS > 1) ? $clog2(NUM_CURSORS) : 1,
  localparam int SW = $clog2(MAX_SIZE + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CURSORS-1:0]             cursor_en,
  input  logic [NUM_CURSORS*XW-1:0]          cursor_x,
  input  logic [NUM_CURSORS*YW-1:0]          cursor_y,
  input  logic [NUM_CURSORS*COLOR_WIDTH-1:0] cursor_color,
  input  logic [NUM_CURSORS*SW-1:0]          cursor_size,
  input  logic [XW-1:0]                      request_x,
  input  logic [YW-1:0]                      request_y,
  output logic [COLOR_WIDTH-1:0]             render_color,
  output logic                               busy
);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_SCAN,
    S_ERASE,
    S_DRAW
  } state_t;

  state_t r_state;

  logic [IW-1:0] r_ptr;
  logic [XW-1:0] r_cx;
  logic [YW-1:0] r_cy;
  logic [SW-1:0] r_px;
  logic [SW-1:0] r_py;

  logic [NUM_CURSORS-1:0] r_d_en;
  logic [NUM_CURSORS-1:0] r_redraw;
  logic [XW-1:0]          r_d_x    [NUM_CURSORS];
  logic [YW-1:0]          r_d_y    [NUM_CURSORS];
  logic [COLOR_WIDTH-1:0] r_d_col  [NUM_CURSORS];
  logic [SW-1:0]          r_d_size [NUM_CURSORS];

  logic                   r_t_en;
  logic [XW-1:0]          r_t_x;
  logic [YW-1:0]          r_t_y;
  logic [COLOR_WIDTH-1:0] r_t_col;
  logic [SW-1:0]          r_t_size;

  // footprint currently being walked (drawn_* in ERASE, target in DRAW)
  logic [XW-1:0] r_b_x;
  logic [YW-1:0] r_b_y;
  logic [SW-1:0] r_b_size;

  logic [COLOR_WIDTH-1:0] r_mem [WIDTH][HEIGHT];

  logic                   w_c_en;
  logic [XW-1:0]          w_c_x;
  logic [YW-1:0]          w_c_y;
  logic [COLOR_WIDTH-1:0] w_c_col;
  logic [SW-1:0]          w_c_raw;
  logic [SW-1:0]          w_c_size;
  logic                   w_c_on;
  logic                   w_changed;
  logic [IW-1:0]          w_ptr_nxt;
  logic [XW:0]            w_fx;
  logic [YW:0]            w_fy;
  logic                   w_px_last;
  logic                   w_fp_last;
  logic                   w_clr_last;
  logic                   w_we;
  logic [XW-1:0]          w_wx;
  logic [YW-1:0]          w_wy;
  logic [COLOR_WIDTH-1:0] w_wc;

  assign w_c_en   = cursor_en[r_ptr];
  assign w_c_x    = cursor_x[r_ptr*XW +: XW];
  assign w_c_y    = cursor_y[r_ptr*YW +: YW];
  assign w_c_col  = cursor_color[r_ptr*COLOR_WIDTH +: COLOR_WIDTH];
  assign w_c_raw  = cursor_size[r_ptr*SW +: SW];
  assign w_c_size = (w_c_raw > SW'(MAX_SIZE)) ? SW'(MAX_SIZE) : w_c_raw;
  assign w_c_on   = w_c_en && (w_c_size != '0);

  assign w_changed =
    (w_c_on != r_d_en[r_ptr]) ||
    (w_c_on && ((w_c_x    != r_d_x[r_ptr])   ||
                (w_c_y    != r_d_y[r_ptr])   ||
                (w_c_col  != r_d_col[r_ptr]) ||
                (w_c_size != r_d_size[r_ptr])));

  assign w_ptr_nxt = (r_ptr == IW'(NUM_CURSORS - 1)) ? '0 : r_ptr + 1'b1;

  // one extra bit so off-screen pixels are clipped, never wrapped
  assign w_fx = {1'b0, r_b_x} + (XW+1)'(r_px);
  assign w_fy = {1'b0, r_b_y} + (YW+1)'(r_py);

  assign w_px_last  = (r_px == r_b_size - SW'(1));
  assign w_fp_last  = w_px_last && (r_py == r_b_size - SW'(1));
  assign w_clr_last = (r_cx == XW'(WIDTH - 1)) &&
                      (r_cy == YW'(HEIGHT - 1));

  assign busy = (r_state != S_SCAN);

  always_comb begin
    w_we = 1'b0;
    w_wx = r_cx;
    w_wy = r_cy;
    w_wc = COLOR_NONE;
    if (!reset) begin
      unique case (r_state)
        S_CLEAR: w_we = 1'b1;
        S_ERASE, S_DRAW: begin
          w_wx = w_fx[XW-1:0];
          w_wy = w_fy[YW-1:0];
          w_we = (w_fx < (XW+1)'(WIDTH)) &&
                 (w_fy < (YW+1)'(HEIGHT));
          if (r_state == S_DRAW) w_wc = r_t_col;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wx][w_wy] <= w_wc;
  end

  always_ff @(posedge clk) begin
    if (reset) render_color <= COLOR_NONE;
    else       render_color <= r_mem[request_x][request_y];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_CLEAR;
      r_ptr    <= '0;
      r_d_en   <= '0;
      r_redraw <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_px     <= '0;
      r_py     <= '0;
    end else begin
      unique case (r_state)
        S_CLEAR: begin
          if (w_clr_last) begin
            r_cx    <= '0;
            r_cy    <= '0;
            r_state <= S_SCAN;
          end else if (r_cx == XW'(WIDTH - 1)) begin
            r_cx <= '0;
            r_cy <= r_cy + 1'b1;
          end else begin
            r_cx <= r_cx + 1'b1;
          end
        end
        S_SCAN: begin
          r_px <= '0;
          r_py <= '0;
          if (w_changed) begin
            r_t_en   <= w_c_on;
            r_t_x    <= w_c_x;
            r_t_y    <= w_c_y;
            r_t_col  <= w_c_col;
            r_t_size <= w_c_size;
            if (r_d_en[r_ptr]) begin
              r_b_x    <= r_d_x[r_ptr];
              r_b_y    <= r_d_y[r_ptr];
              r_b_size <= r_d_size[r_ptr];
              r_state  <= S_ERASE;
            end else if (w_c_on) begin
              r_b_x    <= w_c_x;
              r_b_y    <= w_c_y;
              r_b_size <= w_c_size;
              r_state  <= S_DRAW;
            end else begin
              r_d_en[r_ptr] <= 1'b0;
              r_ptr         <= w_ptr_nxt;
            end
          end else if (r_redraw[r_ptr] && r_d_en[r_ptr]) begin
            // repaint only: the footprint is unchanged, so no erase
            r_t_en   <= 1'b1;
            r_t_x    <= r_d_x[r_ptr];
            r_t_y    <= r_d_y[r_ptr];
            r_t_col  <= r_d_col[r_ptr];
            r_t_size <= r_d_size[r_ptr];
            r_b_x    <= r_d_x[r_ptr];
            r_b_y    <= r_d_y[r_ptr];
            r_b_size <= r_d_size[r_ptr];
            r_state  <= S_DRAW;
          end else begin
            r_ptr <= w_ptr_nxt;
          end
        end
        S_ERASE: begin
          if (w_fp_last) begin
            // the erase may have punched holes in overlapping cursors
            for (int j = 0; j < NUM_CURSORS; j++) begin
              if (IW'(j) != r_ptr && r_d_en[j]) r_redraw[j] <= 1'b1;
            end
            r_d_en[r_ptr] <= 1'b0;
            r_px <= '0;
            r_py <= '0;
            if (r_t_en) begin
              r_b_x    <= r_t_x;
              r_b_y    <= r_t_y;
              r_b_size <= r_t_size;
              r_state  <= S_DRAW;
            end else begin
              r_ptr   <= w_ptr_nxt;
              r_state <= S_SCAN;
            end
          end else if (w_px_last) begin
            r_px <= '0;
            r_py <= r_py + 1'b1;
          end else begin
            r_px <= r_px + 1'b1;
          end
        end
        S_DRAW: begin
          if (w_fp_last) begin
            r_d_en[r_ptr]   <= r_t_en;
            r_d_x[r_ptr]    <= r_t_x;
            r_d_y[r_ptr]    <= r_t_y;
            r_d_col[r_ptr]  <= r_t_col;
            r_d_size[r_ptr] <= r_t_size;
            r_redraw[r_ptr] <= 1'b0;
            r_ptr   <= w_ptr_nxt;
            r_state <= S_SCAN;
          end else if (w_px_last) begin
            r_px <= '0;
            r_py <= r_py + 1'b1;
          end else begin
            r_px <= r_px + 1'b1;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

endmodule
